inc_rom_arbiter: RTL and testbench
==================================

Name: inc_rom_arbiter

Overview:
Shares one external 4-bit incrementer lookup ROM (in[3:0] -> o[3:0], o = in+1 mod 16, combinational) between two requesters, A and B.
- Owns one 4-bit count register per requester.
- Round-robin arbitrates increment requests.
- Drives the ROM address, captures the ROM result into the granted counter, and returns a one-cycle acknowledge.
- Sits between the requester FSMs and the single shared ROM instance.

Parameters:
WRAP_EN, 1, 1: counter wraps F->0 and pulses wrap_x; 0: counter saturates at F, wrap_x never pulses.

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  reset; synchronous, active-high
req_a  input  1  increment request A; level, held until ack_a
req_b  input  1  increment request B; level, held until ack_b
clr_a  input  1  synchronous clear of cnt_a
clr_b  input  1  synchronous clear of cnt_b
rom_o  input  4  shared ROM data output
rom_in  output  4  shared ROM address input
cnt_a  output  4  counter A (registered)
cnt_b  output  4  counter B (registered)
ack_a  output  1  one-cycle pulse: A's increment complete
ack_b  output  1  one-cycle pulse: B's increment complete
wrap_a  output  1  one-cycle pulse coincident with ack_a when cnt_a went F->0
wrap_b  output  1  one-cycle pulse coincident with ack_b when cnt_b went F->0
busy  output  1  high in SERV and ACK states

Behaviour:
- Reset (rst high at an edge):
  - state=IDLE; cnt_a=cnt_b=0; ack_*=0; wrap_*=0; busy=0; rom_in=0.
  - Round-robin pointer last=B, so A wins the first contention.
  - Reset overrides everything, including an in-flight SERV/ACK; the pending request is dropped with no ack.
- FSM states: IDLE, SERV, ACK.
  - IDLE: sample req_a/req_b.
    - Neither asserted: stay IDLE.
    - One asserted: grant it.
    - Both asserted: grant the one not equal to last.
    - On grant: register gnt, set last=gnt, go to SERV.
  - SERV (1 cycle): rom_in = cnt_gnt (combinational from registered gnt); busy=1. At the closing edge, cnt_gnt <= rom_o, subject to the clear and saturate rules below. Go to ACK.
  - ACK (1 cycle): ack_gnt=1; wrap_gnt=1 if the captured transition was F->0; busy=1. Go to IDLE. Requests are not sampled in ACK.
- rom_in = 0 in IDLE and ACK.
- Latency: req sampled at edge N (IDLE) -> SERV during cycle N+1 -> cnt updated and ack visible during cycle N+2 -> IDLE in cycle N+3.
  - Throughput: one increment per 3 cycles.
- Handshake:
  - A requester deasserts req in the cycle ack is seen.
  - If req is still high when IDLE resumes, it is a new request and gets a new increment.
  - A non-granted requester keeps req high; it is served next, since the pointer guarantees alternation under continuous contention.
- Clear:
  - clr_x forces cnt_x=0 at the next edge in any state, with priority over capture.
  - clr_x during SERV for the granted channel: the capture is discarded, cnt stays 0, ack is still issued, wrap=0.
  - clr_x for the non-granted channel does not disturb the granted transaction.
- WRAP_EN=0: if cnt_gnt==F during SERV, cnt is held at F. Ack is issued, wrap=0.
- The ROM result is trusted as-is; no internal +1 arithmetic. The counter value equals rom_o, 4 bits, no carry out.
- Only one of ack_a/ack_b is ever high in a cycle. The same holds for wrap.

Test Plan:
- Reset then req_a held 1 cycle-pulse-to-ack, cnt_a=0 -> rom_in=0 during SERV, cnt_a=1 and ack_a=1 exactly 2 cycles after the sampling edge, busy high for 2 cycles, cnt_b stays 0.
- req_a and req_b both held continuously from reset for 4 transactions -> grant order A,B,A,B; cnt_a=2, cnt_b=2; no overlapping acks.
- Preload cnt_b=F by 15 increments, then one more req_b -> cnt_b=0, ack_b and wrap_b high in the same cycle. With WRAP_EN=0: cnt_b stays F, wrap_b=0, ack_b=1.
- cnt_a=5, req_a granted, clr_a pulsed during SERV -> cnt_a=0, ack_a=1, wrap_a=0. Repeat with clr_b pulsed instead -> cnt_a=6, cnt_b=0.
- rst asserted during SERV of B with cnt_b=7 -> next cycle: all outputs at reset values, no ack_b, cnt_b=0. First contention after reset grants A.
- req_a held through ack for 3 cycles past ack -> second increment starts in IDLE after ACK, cnt_a advances by 2 total.

Source files
------------

// File: rtl/inc_rom_arbiter.sv
// ---------------------------------------------------------------------------
// inc_rom_arbiter
//
// Two requesters (A and B) share one external combinational 4-bit incrementer
// ROM. This block owns one 4-bit counter per requester. It arbitrates increment
// requests round-robin and drives the ROM address with the granted counter. It
// then captures the ROM result back into that counter and returns a one-cycle
// acknowledge.
//
// Transaction timeline (request sampled at edge N while IDLE):
//   cycle N+1 : SERV - rom_in_o = granted counter, busy_o = 1
//   cycle N+2 : ACK  - counter holds the new value, ack/wrap pulse, busy_o = 1
//   cycle N+3 : IDLE - requests are sampled again
//
// Parameters:
//   WRAP_EN   1: counter wraps F->0 and pulses wrap_x
//             0: counter saturates at F and wrap_x never pulses
//
// Ports:
//   clk_i      system clock, all state updates on the rising edge
//   rst_i      synchronous active-high reset
//   req_a_i    increment request A (level, held until ack_a_o)
//   req_b_i    increment request B (level, held until ack_b_o)
//   clr_a_i    synchronous clear of cnt_a_o (beats any capture)
//   clr_b_i    synchronous clear of cnt_b_o (beats any capture)
//   rom_o_i    shared ROM data output
//   rom_in_o   shared ROM address (granted counter in SERV, else 0)
//   cnt_a_o    counter A (registered)
//   cnt_b_o    counter B (registered)
//   ack_a_o    one-cycle pulse: A's increment complete
//   ack_b_o    one-cycle pulse: B's increment complete
//   wrap_a_o   pulse with ack_a_o when cnt_a went F->0
//   wrap_b_o   pulse with ack_b_o when cnt_b went F->0
//   busy_o     high in SERV and ACK
// ---------------------------------------------------------------------------
module inc_rom_arbiter #(
  parameter bit WRAP_EN = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       req_a_i,
  input  logic       req_b_i,
  input  logic       clr_a_i,
  input  logic       clr_b_i,
  input  logic [3:0] rom_o_i,
  output logic [3:0] rom_in_o,
  output logic [3:0] cnt_a_o,
  output logic [3:0] cnt_b_o,
  output logic       ack_a_o,
  output logic       ack_b_o,
  output logic       wrap_a_o,
  output logic       wrap_b_o,
  output logic       busy_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_SERV = 2'b01,
    ST_ACK  = 2'b10
  } state_e;

  // Grant / round-robin pointer encoding
  localparam logic GNT_A = 1'b0;
  localparam logic GNT_B = 1'b1;

  state_e     state_q, state_d;
  logic       gnt_q, gnt_d;
  logic       last_q, last_d;
  logic [3:0] cnt_a_q, cnt_a_d;
  logic [3:0] cnt_b_q, cnt_b_d;
  logic       ack_a_q, ack_a_d;
  logic       ack_b_q, ack_b_d;
  logic       wrap_a_q, wrap_a_d;
  logic       wrap_b_q, wrap_b_d;
  logic       busy_q, busy_d;

  logic [3:0] cur_cnt_s;   // counter of the registered grant
  logic [3:0] cap_val_s;   // value to store at the end of SERV
  logic       cap_wrap_s;  // the capture is an F->0 transition
  logic [3:0] cap_a_s;     // counter A after capture, before clear
  logic [3:0] cap_b_s;     // counter B after capture, before clear
  logic [3:0] rom_in_s;

  // Select the granted counter and work out what the capture would store
  always_comb begin
    cap_val_s  = rom_o_i;
    cap_wrap_s = 1'b0;
    if (gnt_q == GNT_B) begin
      cur_cnt_s = cnt_b_q;
    end else begin
      cur_cnt_s = cnt_a_q;
    end
    if (cur_cnt_s == 4'hF) begin
      if (WRAP_EN) begin
        // ROM output is trusted as-is; a wrap is F followed by 0
        cap_val_s  = rom_o_i;
        cap_wrap_s = (rom_o_i == 4'h0);
      end else begin
        // Saturating mode: ignore the ROM and hold at F
        cap_val_s  = 4'hF;
        cap_wrap_s = 1'b0;
      end
    end else begin
      cap_val_s  = rom_o_i;
      cap_wrap_s = 1'b0;
    end
  end

  // ROM address is only driven while a transaction is in SERV
  always_comb begin
    if (state_q == ST_SERV) begin
      rom_in_s = cur_cnt_s;
    end else begin
      rom_in_s = 4'h0;
    end
  end

  // Next-state, arbitration and capture logic
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    last_d   = last_q;
    cap_a_s  = cnt_a_q;
    cap_b_s  = cnt_b_q;
    ack_a_d  = 1'b0;
    ack_b_d  = 1'b0;
    wrap_a_d = 1'b0;
    wrap_b_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_a_i && req_b_i) begin
          // Contention: the requester not served last time wins
          gnt_d   = ~last_q;
          last_d  = ~last_q;
          state_d = ST_SERV;
        end else if (req_a_i) begin
          gnt_d   = GNT_A;
          last_d  = GNT_A;
          state_d = ST_SERV;
        end else if (req_b_i) begin
          gnt_d   = GNT_B;
          last_d  = GNT_B;
          state_d = ST_SERV;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_SERV: begin
        state_d = ST_ACK;
        // A clear on the granted channel discards the capture and the wrap,
        // but the requester still receives its acknowledge.
        if (gnt_q == GNT_B) begin
          cap_b_s  = cap_val_s;
          ack_b_d  = 1'b1;
          wrap_b_d = cap_wrap_s & ~clr_b_i;
        end else begin
          cap_a_s  = cap_val_s;
          ack_a_d  = 1'b1;
          wrap_a_d = cap_wrap_s & ~clr_a_i;
        end
      end

      ST_ACK: begin
        // Requests are deliberately not sampled here
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (clr_a_i) begin
      cnt_a_d = 4'h0;
    end else begin
      cnt_a_d = cap_a_s;
    end

    if (clr_b_i) begin
      cnt_b_d = 4'h0;
    end else begin
      cnt_b_d = cap_b_s;
    end

    busy_d = (state_d != ST_IDLE);
  end

  // FSM state, grant and round-robin pointer registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      gnt_q   <= GNT_A;
      last_q  <= GNT_B;   // A wins the first contention after reset
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
    end
  end

  // Counter and registered status output registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_a_q  <= 4'h0;
      cnt_b_q  <= 4'h0;
      ack_a_q  <= 1'b0;
      ack_b_q  <= 1'b0;
      wrap_a_q <= 1'b0;
      wrap_b_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      cnt_a_q  <= cnt_a_d;
      cnt_b_q  <= cnt_b_d;
      ack_a_q  <= ack_a_d;
      ack_b_q  <= ack_b_d;
      wrap_a_q <= wrap_a_d;
      wrap_b_q <= wrap_b_d;
      busy_q   <= busy_d;
    end
  end

  assign rom_in_o = rom_in_s;
  assign cnt_a_o  = cnt_a_q;
  assign cnt_b_o  = cnt_b_q;
  assign ack_a_o  = ack_a_q;
  assign ack_b_o  = ack_b_q;
  assign wrap_a_o = wrap_a_q;
  assign wrap_b_o = wrap_b_q;
  assign busy_o   = busy_q;

endmodule

// File: tb/tb_inc_rom_arbiter.sv
// ---------------------------------------------------------------------------
// tb_inc_rom_arbiter
//
// Drives a wrapping instance (WRAP_EN=1) and a saturating instance
// (WRAP_EN=0) from the same stimulus. Each instance has its own incrementer
// ROM model. A table of per-cycle vectors covers reset, single requests,
// contention and clears. Hand-written sequences cover wrap/saturate and
// reset in the middle of a transaction.
// ---------------------------------------------------------------------------
module tb_inc_rom_arbiter;

  logic       clk;
  logic       rst;
  logic       req_a, req_b, clr_a, clr_b;

  logic [3:0] rom_o1, rom_in1, cnt_a1, cnt_b1;
  logic       ack_a1, ack_b1, wrap_a1, wrap_b1, busy1;
  logic [3:0] rom_o0, rom_in0, cnt_a0, cnt_b0;
  logic       ack_a0, ack_b0, wrap_a0, wrap_b0, busy0;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  // Incrementer ROM models (one per instance)
  assign rom_o1 = rom_in1 + 4'd1;
  assign rom_o0 = rom_in0 + 4'd1;

  inc_rom_arbiter #(.WRAP_EN(1'b1)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_a_i(req_a), .req_b_i(req_b), .clr_a_i(clr_a), .clr_b_i(clr_b),
    .rom_o_i(rom_o1), .rom_in_o(rom_in1),
    .cnt_a_o(cnt_a1), .cnt_b_o(cnt_b1),
    .ack_a_o(ack_a1), .ack_b_o(ack_b1),
    .wrap_a_o(wrap_a1), .wrap_b_o(wrap_b1), .busy_o(busy1)
  );

  inc_rom_arbiter #(.WRAP_EN(1'b0)) dut_sat (
    .clk_i(clk), .rst_i(rst),
    .req_a_i(req_a), .req_b_i(req_b), .clr_a_i(clr_a), .clr_b_i(clr_b),
    .rom_o_i(rom_o0), .rom_in_o(rom_in0),
    .cnt_a_o(cnt_a0), .cnt_b_o(cnt_b0),
    .ack_a_o(ack_a0), .ack_b_o(ack_b0),
    .wrap_a_o(wrap_a0), .wrap_b_o(wrap_b0), .busy_o(busy0)
  );

  // Clock generation
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Continuous mutual-exclusion check on acks and wraps
  always @(negedge clk) begin
    if (mon_en) begin
      checks = checks + 1;
      if ((ack_a1 && ack_b1) || (wrap_a1 && wrap_b1) ||
          (ack_a0 && ack_b0) || (wrap_a0 && wrap_b0)) begin
        errors = errors + 1;
        $display("FAIL onehot t=%0t ack=%b%b wrap=%b%b sat ack=%b%b wrap=%b%b required at most one high",
                 $time, ack_a1, ack_b1, wrap_a1, wrap_b1, ack_a0, ack_b0, wrap_a0, wrap_b0);
      end
    end
  end

  // inp = {rst, req_a, req_b, clr_a, clr_b}
  // flg = {ack_a, ack_b, wrap_a, wrap_b, busy}
  typedef struct packed {
    logic [4:0] inp;
    logic [3:0] cnt_a;
    logic [3:0] cnt_b;
    logic [3:0] rom_in;
    logic [4:0] flg;
  } vec_t;

  localparam int NVEC = 33;
  vec_t vecs [NVEC];

  function automatic vec_t mk(input logic [4:0] inp, input logic [3:0] ea,
                              input logic [3:0] eb, input logic [3:0] er,
                              input logic [4:0] fl);
    vec_t v;
    v.inp = inp; v.cnt_a = ea; v.cnt_b = eb; v.rom_in = er; v.flg = fl;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  // One increment on channel ch (0=A,1=B); returns both instances' state at ack
  task automatic do_inc(input logic ch, output logic [3:0] c1, output logic w1,
                        output logic [3:0] c0, output logic w0, output logic ak0);
    bit seen;
    seen = 1'b0;
    c1 = 4'h0; w1 = 1'b0; c0 = 4'h0; w0 = 1'b0; ak0 = 1'b0;
    @(negedge clk);
    if (ch) req_b = 1'b1; else req_a = 1'b1;
    for (int i = 0; i < 6 && !seen; i++) begin
      @(posedge clk); #1;
      if (ch ? ack_b1 : ack_a1) begin
        seen = 1'b1;
        c1  = ch ? cnt_b1 : cnt_a1;
        w1  = ch ? wrap_b1 : wrap_a1;
        c0  = ch ? cnt_b0 : cnt_a0;
        w0  = ch ? wrap_b0 : wrap_a0;
        ak0 = ch ? ack_b0 : ack_a0;
      end
    end
    if (!seen) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL ack_timeout ch=%0d actual=no_ack required=ack", ch);
    end
    @(negedge clk);
    req_a = 1'b0; req_b = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [3:0] c1, c0;
    logic       w1, w0, ak0;
    logic [3:0] exp_b1, exp_b0;

    rst = 1'b1; req_a = 1'b0; req_b = 1'b0; clr_a = 1'b0; clr_b = 1'b0;

    vecs[0]  = mk(5'b10000, 4'h0, 4'h0, 4'h0, 5'b00000);
    // single request A
    vecs[1]  = mk(5'b01000, 4'h0, 4'h0, 4'h0, 5'b00001);
    vecs[2]  = mk(5'b01000, 4'h1, 4'h0, 4'h0, 5'b10001);
    vecs[3]  = mk(5'b00000, 4'h1, 4'h0, 4'h0, 5'b00000);
    vecs[4]  = mk(5'b00000, 4'h1, 4'h0, 4'h0, 5'b00000);
    // reset, then continuous contention: A,B,A,B
    vecs[5]  = mk(5'b10000, 4'h0, 4'h0, 4'h0, 5'b00000);
    vecs[6]  = mk(5'b01100, 4'h0, 4'h0, 4'h0, 5'b00001);
    vecs[7]  = mk(5'b01100, 4'h1, 4'h0, 4'h0, 5'b10001);
    vecs[8]  = mk(5'b01100, 4'h1, 4'h0, 4'h0, 5'b00000);
    vecs[9]  = mk(5'b01100, 4'h1, 4'h0, 4'h0, 5'b00001);
    vecs[10] = mk(5'b01100, 4'h1, 4'h1, 4'h0, 5'b01001);
    vecs[11] = mk(5'b01100, 4'h1, 4'h1, 4'h0, 5'b00000);
    vecs[12] = mk(5'b01100, 4'h1, 4'h1, 4'h1, 5'b00001);
    vecs[13] = mk(5'b01100, 4'h2, 4'h1, 4'h0, 5'b10001);
    vecs[14] = mk(5'b01100, 4'h2, 4'h1, 4'h0, 5'b00000);
    vecs[15] = mk(5'b01100, 4'h2, 4'h1, 4'h1, 5'b00001);
    vecs[16] = mk(5'b01100, 4'h2, 4'h2, 4'h0, 5'b01001);
    vecs[17] = mk(5'b00000, 4'h2, 4'h2, 4'h0, 5'b00000);
    // req_a held past ack: two back-to-back increments
    vecs[18] = mk(5'b01000, 4'h2, 4'h2, 4'h2, 5'b00001);
    vecs[19] = mk(5'b01000, 4'h3, 4'h2, 4'h0, 5'b10001);
    vecs[20] = mk(5'b01000, 4'h3, 4'h2, 4'h0, 5'b00000);
    vecs[21] = mk(5'b01000, 4'h3, 4'h2, 4'h3, 5'b00001);
    vecs[22] = mk(5'b01000, 4'h4, 4'h2, 4'h0, 5'b10001);
    vecs[23] = mk(5'b00000, 4'h4, 4'h2, 4'h0, 5'b00000);
    vecs[24] = mk(5'b01000, 4'h4, 4'h2, 4'h4, 5'b00001);
    vecs[25] = mk(5'b01000, 4'h5, 4'h2, 4'h0, 5'b10001);
    vecs[26] = mk(5'b00000, 4'h5, 4'h2, 4'h0, 5'b00000);
    // cnt_a=5 granted, clr_b in SERV: A unaffected, B cleared
    vecs[27] = mk(5'b01000, 4'h5, 4'h2, 4'h5, 5'b00001);
    vecs[28] = mk(5'b01001, 4'h6, 4'h0, 4'h0, 5'b10001);
    vecs[29] = mk(5'b00000, 4'h6, 4'h0, 4'h0, 5'b00000);
    // clr_a in SERV of A: capture discarded, ack still issued
    vecs[30] = mk(5'b01000, 4'h6, 4'h0, 4'h6, 5'b00001);
    vecs[31] = mk(5'b01010, 4'h0, 4'h0, 4'h0, 5'b10001);
    vecs[32] = mk(5'b00000, 4'h0, 4'h0, 4'h0, 5'b00000);

    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      {rst, req_a, req_b, clr_a, clr_b} = vecs[i].inp;
      @(posedge clk); #1;
      mon_en = 1'b1;
      chk($sformatf("vec%0d", i),
          {15'd0, cnt_a1, cnt_b1, rom_in1, ack_a1, ack_b1, wrap_a1, wrap_b1, busy1},
          {15'd0, vecs[i].cnt_a, vecs[i].cnt_b, vecs[i].rom_in, vecs[i].flg});
      chk($sformatf("vec%0d_sat", i),
          {15'd0, cnt_a0, cnt_b0, rom_in0, ack_a0, ack_b0, wrap_a0, wrap_b0, busy0},
          {15'd0, vecs[i].cnt_a, vecs[i].cnt_b, vecs[i].rom_in, vecs[i].flg});
    end
    @(negedge clk);
    {rst, req_a, req_b, clr_a, clr_b} = 5'b00000;

    // Wrap / saturate: 16 increments of B starting from 0
    exp_b1 = 4'h0;
    exp_b0 = 4'h0;
    for (int k = 1; k <= 16; k++) begin
      do_inc(1'b1, c1, w1, c0, w0, ak0);
      exp_b1 = exp_b1 + 4'd1;
      if (exp_b0 != 4'hF) exp_b0 = exp_b0 + 4'd1;
      chk($sformatf("wrap_inc%0d", k), {27'd0, c1, w1}, {27'd0, exp_b1, (k == 16) ? 1'b1 : 1'b0});
      chk($sformatf("sat_inc%0d", k), {26'd0, c0, w0, ak0}, {26'd0, exp_b0, 1'b0, 1'b1});
    end

    // Bring B to 7, then reset in the middle of its SERV
    for (int k = 1; k <= 7; k++) begin
      do_inc(1'b1, c1, w1, c0, w0, ak0);
    end
    chk("cnt_b_pre_rst", {28'd0, cnt_b1}, {28'd0, 4'h7});
    @(negedge clk);
    req_b = 1'b1;
    @(posedge clk); #1;
    chk("serv_b7", {27'd0, busy1, rom_in1}, {27'd0, 1'b1, 4'h7});
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_serv",
        {15'd0, cnt_a1, cnt_b1, rom_in1, ack_a1, ack_b1, wrap_a1, wrap_b1, busy1}, 32'd0);
    chk("rst_in_serv_sat",
        {15'd0, cnt_a0, cnt_b0, rom_in0, ack_a0, ack_b0, wrap_a0, wrap_b0, busy0}, 32'd0);
    @(negedge clk);
    rst = 1'b0; req_b = 1'b0;
    @(posedge clk); #1;
    chk("no_ack_after_rst", {29'd0, ack_b1, busy1, cnt_b1 == 4'h0}, {29'd0, 1'b0, 1'b0, 1'b1});

    // First contention after reset must go to A
    @(negedge clk);
    req_a = 1'b1; req_b = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_serv", {27'd0, busy1, rom_in1}, {27'd0, 1'b1, 4'h0});
    @(posedge clk); #1;
    chk("post_rst_grant_a", {22'd0, ack_a1, ack_b1, cnt_a1, cnt_b1},
        {22'd0, 1'b1, 1'b0, 4'h1, 4'h0});
    @(negedge clk);
    req_a = 1'b0; req_b = 1'b0;
    @(posedge clk); #1;
    mon_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
